mat_cache_diag_seq: RTL and testbench
=====================================

# mat_cache_diag_seq

Sequencer that owns one MatCache instance and runs the load-then-diagonal-drain pattern used to feed the systolic matrix unit. It accepts a command naming a cache slot, streams WIDTH rows from an upstream valid/ready source into that slot with MAT_CACHE_WRITE_ROW, then reads the slot back as WIDTH diagonals with MAT_CACHE_READ_DIAG onto a downstream valid/ready port. It sits between the matrix load path and the MatCache, and is the only driver of the cache's op, address and param ports.

## Interface
- WIDTH, default 4: matrix dimension; one row or one diagonal per beat.
- CACHE_SIZE, default 4: number of matrix slots in the MatCache.
- AW = $clog2(CACHE_SIZE), PW = $clog2(WIDTH): derived widths.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  AW  target cache slot.
- cmd_skip_load  in  1  1 means drain only; the slot is already loaded.
- in_valid  in  1  row beat valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  shortreal[WIDTH]  row data, row 0 first.
- out_valid  out  1  diagonal beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  shortreal[WIDTH]  diagonal data.
- out_last  out  1  marks diagonal WIDTH-1.
- busy  out  1  high whenever the state is not IDLE.
- cache_read_op / cache_write_op  out  MatCacheReadOp_t / MatCacheWriteOp_t  cache ops.
- cache_read_addr1, cache_read_addr2, cache_write_addr1, cache_write_addr2  out  AW  cache addresses.
- cache_read_param, cache_write_param  out  PW  row index or diagonal index.
- cache_data_in  out  shortreal[WIDTH]  driven equal to in_data.
- cache_data_out  in  shortreal[WIDTH]  cache read data; combinational from the read op, address and param.

## Operation
- States are IDLE, LOAD and DRAIN. Registers: slot (AW bits), cnt (PW bits).
- **IDLE:**
  - On cmd_valid, capture cmd_addr into slot and clear cnt.
  - Next state is DRAIN if cmd_skip_load is set, otherwise LOAD.
- **LOAD:**
  - in_ready = 1.
  - When in_valid is high: cache_write_op = MAT_CACHE_WRITE_ROW, cache_write_addr1 = slot, cache_write_param = cnt. cnt increments on that edge.
  - When in_valid is low: cache_write_op = MAT_CACHE_WRITE_NONE.
  - After the beat with cnt == WIDTH-1 is accepted, clear cnt and go to DRAIN.
- **DRAIN:**
  - cache_read_op = MAT_CACHE_READ_DIAG; cache_read_addr1 = cache_read_addr2 = slot; cache_read_param = cnt.
  - out_valid = 1; out_data = cache_data_out; out_last = (cnt == WIDTH-1).
  - On out_ready, cnt increments. On the out_last handshake, go to IDLE.
- Diagonal k is element i = M[i][(i+k) mod WIDTH]. This is the MatCache READ_DIAG definition.
- Outside LOAD, cache_write_op = MAT_CACHE_WRITE_NONE. Outside DRAIN, cache_read_op = MAT_CACHE_READ_NONE.
- Unused addresses and params are driven to 0.
- cnt wraps to 0 after WIDTH-1. It never exceeds WIDTH-1.

## Timing
- **Reset:**
  - State = IDLE, slot = 0, cnt = 0.
  - cmd_ready = 1; in_ready, out_valid, out_last and busy = 0.
  - Cache ops = NONE; all addresses and params = 0.
- **Reset mid-operation:** the state returns to IDLE immediately and asynchronously. Write ops go to NONE in the same instant, so no partial-row write is committed at the next edge. Rows already written remain in the cache.
- **Command acceptance:** one cycle from cmd handshake to the first in_ready. Commands are not accepted while busy.
- **LOAD throughput:** one row per cycle. A row is committed at the edge where in_valid && in_ready.
- **LOAD to DRAIN:** the first diagonal is presented in the cycle after the last row write edge, so the read sees the committed data.
- **Minimum command duration:** 1 + WIDTH + WIDTH cycles, back to back, with no stalls. A new command can be accepted in the cycle after the out_last handshake.
- **Output backpressure:** while out_valid && !out_ready, cache_read_param and out_data stay stable.
- **Input backpressure:** an in_valid gap inserts idle cycles with no write.
- The cache is single-ported by use, so reads and writes never occur in the same cycle.
- **Simultaneous events:**
  - cmd_valid in the same cycle as the final out_last handshake is not accepted, because cmd_ready = 0 in DRAIN.
  - in_valid in DRAIN or IDLE is ignored.

## Test plan
- **Basic load and drain:** WIDTH=4, cmd_addr=0. Load rows (4,6,1,6), (1,2,3,4), (3,3,3,3), (9,7,5,3) with no stalls.
  - Required: exactly 4 MAT_CACHE_WRITE_ROW cycles with params 0..3.
  - Required diagonals: diag0 = (4,2,3,3), diag1 = (6,3,3,9), diag2 = (1,4,3,7), diag3 = (6,1,3,5).
  - Required: out_last only on diag3, and busy drops the cycle after it.
- **Input stalls:** same data, in_valid toggled 1,0,0,1,... Required: writes occur only on handshake cycles, row params stay in order 0..3, and the output is identical to the basic case.
- **Output stalls:** hold out_ready = 0 for 3 cycles on diag1. Required: read_param stays 1 and out_data stays (6,3,3,9) throughout; no diagonal is skipped or repeated.
- **Skip-load:** cmd_skip_load = 1 on slot 2, which was previously loaded. Required: no write cycles, and DRAIN starts one cycle after command acceptance with read_addr1 = 2.
- **Reset mid-LOAD:** assert reset after 2 rows are written. Required:
  - write_op is NONE immediately, state is IDLE, and cmd_ready = 1.
  - A fresh command to slot 1 then completes normally.
- **Command while busy:** cmd_valid is held high during LOAD and DRAIN. Required:
  - cmd_ready = 0 throughout and slot is unchanged.
  - The held command is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/mat_cache_diag_seq.sv
// mat_cache_diag_seq: owns the MatCache op/address/param ports and runs
// load-rows-then-drain-diagonals for one cache slot per command.
// Data words are IEEE-754 single-precision bit patterns carried opaquely
// (the sequencer only routes them, it never does arithmetic on them).

package mat_cache_pkg;
  typedef enum logic [1:0] {
    MAT_CACHE_READ_NONE = 2'd0,
    MAT_CACHE_READ_ROW  = 2'd1,
    MAT_CACHE_READ_COL  = 2'd2,
    MAT_CACHE_READ_DIAG = 2'd3
  } MatCacheReadOp_t;

  typedef enum logic [1:0] {
    MAT_CACHE_WRITE_NONE = 2'd0,
    MAT_CACHE_WRITE_ROW  = 2'd1,
    MAT_CACHE_WRITE_COL  = 2'd2
  } MatCacheWriteOp_t;
endpackage

// state   | meaning
// S_IDLE  | waiting for a command; only state with cmd_ready high
// S_LOAD  | accepting WIDTH rows, one MAT_CACHE_WRITE_ROW per handshake
// S_DRAIN | presenting WIDTH diagonals via MAT_CACHE_READ_DIAG
module mat_cache_diag_seq
  import mat_cache_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4,
  localparam int AW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [AW-1:0]               i_cmd_addr,
  input  logic                        i_cmd_skip_load,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [WIDTH-1:0][31:0]      i_in_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [WIDTH-1:0][31:0]      o_out_data,
  output logic                        o_out_last,
  output logic                        o_busy,
  output MatCacheReadOp_t             o_cache_read_op,
  output MatCacheWriteOp_t            o_cache_write_op,
  output logic [AW-1:0]               o_cache_read_addr1,
  output logic [AW-1:0]               o_cache_read_addr2,
  output logic [AW-1:0]               o_cache_write_addr1,
  output logic [AW-1:0]               o_cache_write_addr2,
  output logic [PW-1:0]               o_cache_read_param,
  output logic [PW-1:0]               o_cache_write_param,
  output logic [WIDTH-1:0][31:0]      o_cache_data_in,
  input  logic [WIDTH-1:0][31:0]      i_cache_data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_slot;
  logic [PW-1:0] r_cnt;
  logic          w_cnt_last;
  logic [PW-1:0] w_cnt_inc;

  // Row/diagonal index wraps to 0 after WIDTH-1, so the last beat of LOAD
  // leaves cnt ready for diagonal 0 without a separate clear.
  assign w_cnt_last = (r_cnt == PW'(WIDTH - 1));
  assign w_cnt_inc  = w_cnt_last ? '0 : r_cnt + PW'(1);

  // Write data is a straight pass-through; the op qualifies it.
  assign o_cache_data_in = i_in_data;

  // State, captured slot and beat counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_slot <= i_cmd_addr;
            r_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (i_in_valid) r_cnt <= w_cnt_inc;
        end
        S_DRAIN: begin
          if (i_out_ready) r_cnt <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // Next state and all outputs; ops are decoded from the current state so an
  // async reset drops a pending row write in the same instant.
  always_comb begin
    w_state_nxt         = r_state;
    o_cmd_ready         = 1'b0;
    o_in_ready          = 1'b0;
    o_out_valid         = 1'b0;
    o_out_data          = '0;
    o_out_last          = 1'b0;
    o_busy              = 1'b1;
    o_cache_read_op     = MAT_CACHE_READ_NONE;
    o_cache_write_op    = MAT_CACHE_WRITE_NONE;
    o_cache_read_addr1  = '0;
    o_cache_read_addr2  = '0;
    o_cache_write_addr1 = '0;
    o_cache_write_addr2 = '0;
    o_cache_read_param  = '0;
    o_cache_write_param = '0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) begin
          w_state_nxt = i_cmd_skip_load ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          o_cache_write_op    = MAT_CACHE_WRITE_ROW;
          o_cache_write_addr1 = r_slot;
          o_cache_write_param = r_cnt;
          if (w_cnt_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_cache_read_op    = MAT_CACHE_READ_DIAG;
        o_cache_read_addr1 = r_slot;
        o_cache_read_addr2 = r_slot;
        o_cache_read_param = r_cnt;
        o_out_valid        = 1'b1;
        o_out_data         = i_cache_data_out;
        o_out_last         = w_cnt_last;
        if (i_out_ready && w_cnt_last) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mat_cache_diag_seq.sv
// Directed bench for mat_cache_diag_seq with a behavioural MatCache model and
// a scoreboard of expected diagonals.
module tb_mat_cache_diag_seq;
  import mat_cache_pkg::*;

  localparam int W  = 4;
  localparam int CS = 4;

  typedef logic [W-1:0][31:0] row_t;
  typedef struct packed {
    row_t       data;
    logic       last;
    logic [1:0] param;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_addr;
  logic             i_cmd_skip_load;
  logic             i_in_valid;
  logic             o_in_ready;
  row_t             i_in_data;
  logic             o_out_valid;
  logic             i_out_ready;
  row_t             o_out_data;
  logic             o_out_last;
  logic             o_busy;
  MatCacheReadOp_t  o_cache_read_op;
  MatCacheWriteOp_t o_cache_write_op;
  logic [1:0]       o_cache_read_addr1;
  logic [1:0]       o_cache_read_addr2;
  logic [1:0]       o_cache_write_addr1;
  logic [1:0]       o_cache_write_addr2;
  logic [1:0]       o_cache_read_param;
  logic [1:0]       o_cache_write_param;
  row_t             o_cache_data_in;
  row_t             i_cache_data_out;

  mat_cache_diag_seq #(.WIDTH(W), .CACHE_SIZE(CS)) u_dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_cmd_valid         (i_cmd_valid),
    .o_cmd_ready         (o_cmd_ready),
    .i_cmd_addr          (i_cmd_addr),
    .i_cmd_skip_load     (i_cmd_skip_load),
    .i_in_valid          (i_in_valid),
    .o_in_ready          (o_in_ready),
    .i_in_data           (i_in_data),
    .o_out_valid         (o_out_valid),
    .i_out_ready         (i_out_ready),
    .o_out_data          (o_out_data),
    .o_out_last          (o_out_last),
    .o_busy              (o_busy),
    .o_cache_read_op     (o_cache_read_op),
    .o_cache_write_op    (o_cache_write_op),
    .o_cache_read_addr1  (o_cache_read_addr1),
    .o_cache_read_addr2  (o_cache_read_addr2),
    .o_cache_write_addr1 (o_cache_write_addr1),
    .o_cache_write_addr2 (o_cache_write_addr2),
    .o_cache_read_param  (o_cache_read_param),
    .o_cache_write_param (o_cache_write_param),
    .o_cache_data_in     (o_cache_data_in),
    .i_cache_data_out    (i_cache_data_out)
  );

  always #5 i_clk = ~i_clk;

  // MatCache model: row writes on the edge, combinational diagonal reads.
  row_t mem [CS][W] = '{default: '0};
  int   n_wr = 0;

  always @(posedge i_clk) begin
    if (o_cache_write_op == MAT_CACHE_WRITE_ROW) begin
      mem[o_cache_write_addr1][o_cache_write_param] <= o_cache_data_in;
      n_wr <= n_wr + 1;
    end
  end

  always_comb begin
    i_cache_data_out = '0;
    if (o_cache_read_op == MAT_CACHE_READ_DIAG) begin
      for (int i = 0; i < W; i++)
        i_cache_data_out[i] = mem[o_cache_read_addr1][i][(i + int'(o_cache_read_param)) % W];
    end
  end

  // Bench state: source matrices, shadow of what each slot should hold.
  row_t src    [2][W];
  row_t shadow [CS][W];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   held  = 1'b0;
  int   wr0;

  function automatic row_t mk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_diags(input logic [1:0] slot);
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e = '0;
      for (int i = 0; i < W; i++) e.data[i] = shadow[slot][i][(i + k) % W];
      e.last  = (k == W - 1);
      e.param = 2'(k);
      sb.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [1:0] slot, input bit skip, input bit hold);
    i_cmd_valid = 1'b1; i_cmd_addr = slot; i_cmd_skip_load = skip;
    #1;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    chk("busy_idle", o_busy, 0);
    @(negedge i_clk);
    if (!hold) i_cmd_valid = 1'b0;
  endtask

  task automatic load_rows(input logic [1:0] slot, input int set, input bit stall);
    int r = 0;
    int c = 0;
    while (r < W && c < 4 * W) begin
      if (stall && (c % 3) != 0) begin
        i_in_valid = 1'b0; i_in_data = mk(99, 99, 99, 99);
        #1;
        chk("gap_write_op", o_cache_write_op, MAT_CACHE_WRITE_NONE);
        chk("gap_in_ready", o_in_ready, 1);
      end else begin
        i_in_valid = 1'b1; i_in_data = src[set][r];
        #1;
        chk("load_in_ready", o_in_ready, 1);
        chk("load_write_op", o_cache_write_op, MAT_CACHE_WRITE_ROW);
        chk("load_write_addr1", o_cache_write_addr1, slot);
        chk("load_write_param", o_cache_write_param, r);
        chk("load_read_op", o_cache_read_op, MAT_CACHE_READ_NONE);
        chk("load_data_in", o_cache_data_in, src[set][r]);
        chk("load_busy", o_busy, 1);
        shadow[slot][r] = src[set][r];
        r++;
      end
      if (held) chk("load_cmd_ready_held", o_cmd_ready, 0);
      c++;
      @(negedge i_clk);
    end
    push_diags(slot);
  endtask

  task automatic drain_all(input logic [1:0] slot, input int stall_k, input int stall_n);
    exp_t e;
    i_in_valid = 1'b1; i_in_data = mk(77, 77, 77, 77);
    for (int k = 0; k < W; k++) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 0, 1);
        e = '0;
      end else begin
        e = sb.pop_front();
      end
      for (int s = 0; s < ((k == stall_k) ? stall_n : 0); s++) begin
        i_out_ready = 1'b0;
        #1;
        chk("stall_out_valid", o_out_valid, 1);
        chk("stall_read_param", o_cache_read_param, e.param);
        chk("stall_out_data", o_out_data, e.data);
        chk("stall_read_addr1", o_cache_read_addr1, slot);
        @(negedge i_clk);
      end
      i_out_ready = 1'b1;
      #1;
      chk("drain_out_valid", o_out_valid, 1);
      chk("drain_out_data", o_out_data, e.data);
      chk("drain_out_last", o_out_last, e.last);
      chk("drain_read_param", o_cache_read_param, e.param);
      chk("drain_read_addr1", o_cache_read_addr1, slot);
      chk("drain_read_addr2", o_cache_read_addr2, slot);
      chk("drain_read_op", o_cache_read_op, MAT_CACHE_READ_DIAG);
      chk("drain_write_op", o_cache_write_op, MAT_CACHE_WRITE_NONE);
      chk("drain_in_ready", o_in_ready, 0);
      chk("drain_busy", o_busy, 1);
      if (held) chk("drain_cmd_ready_held", o_cmd_ready, 0);
      @(negedge i_clk);
    end
    i_out_ready = 1'b0; i_in_valid = 1'b0;
  endtask

  task automatic idle_check();
    #1;
    chk("idle_busy", o_busy, 0);
    chk("idle_cmd_ready", o_cmd_ready, 1);
    chk("idle_out_valid", o_out_valid, 0);
    chk("idle_in_ready", o_in_ready, 0);
    chk("idle_read_op", o_cache_read_op, MAT_CACHE_READ_NONE);
    chk("idle_write_op", o_cache_write_op, MAT_CACHE_WRITE_NONE);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_skip_load = 1'b0;
    i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
    src[0][0] = mk(4, 6, 1, 6);  src[0][1] = mk(1, 2, 3, 4);
    src[0][2] = mk(3, 3, 3, 3);  src[0][3] = mk(9, 7, 5, 3);
    src[1][0] = mk(1, 2, 3, 4);  src[1][1] = mk(5, 6, 7, 8);
    src[1][2] = mk(9, 10, 11, 12); src[1][3] = mk(13, 14, 15, 16);
    for (int s = 0; s < CS; s++)
      for (int r = 0; r < W; r++) shadow[s][r] = '0;

    // Reset values
    #2;
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_last", o_out_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_read_op", o_cache_read_op, MAT_CACHE_READ_NONE);
    chk("rst_write_op", o_cache_write_op, MAT_CACHE_WRITE_NONE);
    chk("rst_addrs", {o_cache_read_addr1, o_cache_read_addr2, o_cache_write_addr1, o_cache_write_addr2}, 0);
    chk("rst_params", {o_cache_read_param, o_cache_write_param}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Basic load and drain, slot 0
    wr0 = n_wr;
    send_cmd(2'd0, 1'b0, 1'b0);
    load_rows(2'd0, 0, 1'b0);
    chk("basic_write_count", n_wr - wr0, 4);
    drain_all(2'd0, -1, 0);
    idle_check();

    // Input stalls, slot 2
    wr0 = n_wr;
    send_cmd(2'd2, 1'b0, 1'b0);
    load_rows(2'd2, 0, 1'b1);
    chk("stall_in_write_count", n_wr - wr0, 4);
    drain_all(2'd2, -1, 0);
    idle_check();

    // Output stalls on diag1, slot 3
    send_cmd(2'd3, 1'b0, 1'b0);
    load_rows(2'd3, 0, 1'b0);
    drain_all(2'd3, 1, 3);
    idle_check();

    // Skip-load of slot 2
    wr0 = n_wr;
    push_diags(2'd2);
    send_cmd(2'd2, 1'b1, 1'b0);
    drain_all(2'd2, -1, 0);
    chk("skip_write_count", n_wr - wr0, 0);
    idle_check();

    // Reset mid-LOAD on slot 1 after two rows
    send_cmd(2'd1, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      i_in_valid = 1'b1; i_in_data = src[1][r];
      #1;
      chk("pre_rst_write_param", o_cache_write_param, r);
      shadow[1][r] = src[1][r];
      @(negedge i_clk);
    end
    i_in_valid = 1'b1; i_in_data = src[1][2];
    i_rst = 1'b1;
    #1;
    chk("mid_rst_write_op", o_cache_write_op, MAT_CACHE_WRITE_NONE);
    chk("mid_rst_cmd_ready", o_cmd_ready, 1);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_in_ready", o_in_ready, 0);
    @(negedge i_clk);
    chk("mid_rst_row2_unwritten", mem[1][2], 0);
    chk("mid_rst_row1_kept", mem[1][1], src[1][1]);
    i_rst = 1'b0; i_in_valid = 1'b0;
    @(negedge i_clk);
    idle_check();
    send_cmd(2'd1, 1'b0, 1'b0);
    load_rows(2'd1, 1, 1'b0);
    drain_all(2'd1, -1, 0);
    idle_check();

    // Command held high while busy
    held = 1'b1;
    send_cmd(2'd0, 1'b0, 1'b1);
    i_cmd_addr = 2'd3; i_cmd_skip_load = 1'b1;
    load_rows(2'd0, 1, 1'b0);
    drain_all(2'd0, -1, 0);
    #1;
    chk("held_first_idle_cmd_ready", o_cmd_ready, 1);
    chk("held_first_idle_busy", o_busy, 0);
    push_diags(2'd3);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    held = 1'b0;
    drain_all(2'd3, -1, 0);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
